burst_packer: RTL and testbench
===============================

// Module: burst_packer
// PURPOSE
//  Multi-channel successor to the single-pair data/weight BRAM write packers fed by okBTPipeIn endpoints.
//  Each channel packs SAMPLE_W-bit samples into BURST_LEN-sample words and writes them to its BRAM port.
//  Adds programmable base/last address with wrap, a sticky wrap flag, a word counter and synchronous clear.
//  Sits in the okClk domain, between the pipe-in endpoints and the d/w (and future bias) BRAM write ports.
// PARAMETERS
//  NUM_CH     2   number of independent packing channels
//  SAMPLE_W   16  bits taken from in_data[31:0] of each channel (LSBs); range 1..32
//  BURST_LEN  4   samples per BRAM word; word width = SAMPLE_W*BURST_LEN; range >= 2
//  ADDR_W     10  BRAM write address width
// PORTS
//  clk          in   1                     okClk-domain clock
//  rst_n        in   1                     asynchronous active-low reset
//  clear        in   NUM_CH                sync per-channel clear: count/addr/shift/word_cnt -> init, wrapped -> 0
//  in_valid     in   NUM_CH                per-channel sample strobe (ep_write)
//  in_data      in   32*NUM_CH             per-channel sample; channel c at [32c+:32]
//  flush        in   NUM_CH                per-channel flush of a partial word (see CONFIGURATION)
//  cfg_base     in   ADDR_W*NUM_CH         first write address per channel
//  cfg_last     in   ADDR_W*NUM_CH         last write address per channel before wrap
//  ram_we       out  NUM_CH                registered one-cycle BRAM write strobe
//  ram_addr     out  ADDR_W*NUM_CH         registered BRAM address, valid when ram_we is high
//  ram_data     out  SAMPLE_W*BURST_LEN*NUM_CH  registered packed word
//  word_cnt     out  16*NUM_CH             words written since reset/clear; saturates at 16'hFFFF
//  wrapped      out  NUM_CH                sticky: set when the address wraps cfg_last -> cfg_base
// BEHAVIOUR
//  - Reset (rst_n=0, async): ram_we=0, ram_addr=0, ram_data=0, word_cnt=0, wrapped=0; internal count=0,
//    shift=0, addr pointer=0. After reset the pointer loads cfg_base on the first clear or the first word write.
//  - Channels are fully independent; all may strobe in the same cycle.
//  - Per channel, on in_valid: shift <= {in_data[SAMPLE_W-1:0], shift[top:SAMPLE_W]} (first sample lands in
//    word LSBs); count increments mod BURST_LEN.
//  - When in_valid with count==BURST_LEN-1: next cycle ram_we=1, ram_data=completed word, ram_addr=pointer.
//    Latency: last sample strobe to ram_we = 1 clk. Back-to-back words at full in_valid rate are supported.
//  - Pointer after each write: if pointer==cfg_last -> cfg_base and wrapped<=1; else pointer+1 (mod 2^ADDR_W).
//  - cfg_last < cfg_base: pointer counts up through 2^ADDR_W-1 -> 0, wrapping only on reaching cfg_last.
//  - ram_we is low in every cycle without a completed word; ram_addr/ram_data hold their last values.
//  - word_cnt increments on every ram_we pulse, saturating at 16'hFFFF.
//  - clear has priority over in_valid and flush in the same cycle: that sample is dropped, no write.
//    clear sets pointer <= cfg_base, count=0, shift=0, word_cnt=0, wrapped=0; ram_we=0 next cycle.
//  - cfg_base/cfg_last are sampled only at clear/wrap; changing them mid-burst is not an error.
//  - Reset mid-burst discards the partial word; no write is issued.
// CONFIGURATION
//  BURST_PACKER_FLUSH_EN defined: flush with count>0 emits the partial word next cycle, unfilled upper
//    samples zero, shifted down so sample 0 sits in LSBs; count/shift then clear. flush with count==0: no
//    write. flush with in_valid in the same cycle: the sample is included first, then the word is flushed
//    (if that sample completes the word, one normal write only).
//  BURST_PACKER_FLUSH_EN undefined: flush is ignored; partial words are held until completed or cleared.
// TESTING
//  1 NUM_CH=2,BURST_LEN=4,base=0: ch0 strobes 16'h0001..0004 -> 1 clk after 4th: we[0]=1, addr=0,
//    data=64'h0004_0003_0002_0001, word_cnt0=1; ch1 silent, we[1]=0.
//  2 Both channels strobe 8 samples each, every cycle -> 2 writes per ch at addr 0,1; word_cnt=2 each.
//  3 ch0 base=5,last=6: 12 samples -> writes to 5,6,5; wrapped[0] rises with the 2nd write's pointer update.
//  4 clear[0] asserted with the 4th sample's in_valid -> no write; next 4 samples write at cfg_base,
//    word_cnt0=1, wrapped0=0.
//  5 FLUSH_EN: 2 samples 16'hAAAA,16'hBBBB then flush -> data=64'h0000_0000_BBBB_AAAA; flush at count 0 -> none.
//  6 rst_n low mid-burst after 3 samples -> all outputs 0 immediately; 4 samples later write one word only.

Source files
------------

// File: rtl/burst_packer.sv
// Multi-channel sample-to-word packer for pipe-in endpoints feeding BRAM write ports, with address wrap and word counting.
// Optional partial-word flush is enabled by defining BURST_PACKER_FLUSH_EN.
module burst_packer #(
  parameter int NUM_CH    = 2,
  parameter int SAMPLE_W  = 16,
  parameter int BURST_LEN = 4,
  parameter int ADDR_W    = 10
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_CH-1:0]                clear,
  input  logic [NUM_CH-1:0]                in_valid,
  input  logic [32*NUM_CH-1:0]             in_data,
  input  logic [NUM_CH-1:0]                flush,
  input  logic [ADDR_W*NUM_CH-1:0]         cfg_base,
  input  logic [ADDR_W*NUM_CH-1:0]         cfg_last,
  output logic [NUM_CH-1:0]                ram_we,
  output logic [ADDR_W*NUM_CH-1:0]         ram_addr,
  output logic [SAMPLE_W*BURST_LEN*NUM_CH-1:0] ram_data,
  output logic [16*NUM_CH-1:0]             word_cnt,
  output logic [NUM_CH-1:0]                wrapped
);
  localparam int WW = SAMPLE_W * BURST_LEN;
  localparam int CW = $clog2(BURST_LEN);

  // Upper sample bits (and flush, when disabled) are intentionally ignored.
  logic unused_ok_s;
  assign unused_ok_s = ^{in_data, flush};

  genvar c;
  generate
    for (c = 0; c < NUM_CH; c++) begin : g_ch
      logic [CW-1:0]     count_r;
      logic [WW-1:0]     shift_r;
      logic [ADDR_W-1:0] ptr_r;
      logic              loaded_r;
      logic              we_r;
      logic [ADDR_W-1:0] addr_r;
      logic [WW-1:0]     data_r;
      logic [15:0]       cnt_r;
      logic              wrapped_r;

      logic [ADDR_W-1:0] base_s, last_s, cur_addr_s, next_ptr_s;
      logic [WW-1:0]     shift_next_s, flush_word_s, wdata_s;
      logic [CW-1:0]     count_next_s;
      logic              word_done_s, flush_fire_s, write_s, wrap_s;

      assign base_s = cfg_base[ADDR_W*c +: ADDR_W];
      assign last_s = cfg_last[ADDR_W*c +: ADDR_W];

      // Shift register and sample counter advance on each accepted sample.
      always_comb begin
        shift_next_s = shift_r;
        count_next_s = count_r;
        if (in_valid[c]) begin
          shift_next_s = {in_data[32*c +: SAMPLE_W], shift_r[WW-1:SAMPLE_W]};
          if (count_r == CW'(BURST_LEN - 1)) begin
            count_next_s = {CW{1'b0}};
          end else begin
            count_next_s = count_r + CW'(1);
          end
        end else begin
          shift_next_s = shift_r;
          count_next_s = count_r;
        end
      end

      assign word_done_s = in_valid[c] && !clear[c] && (count_r == CW'(BURST_LEN - 1));

`ifdef BURST_PACKER_FLUSH_EN
      logic [CW:0] nsamp_s;
      int          pad_s;
      // Partial word: filled samples sit at the top of the shifter, so slide them down to the LSBs.
      always_comb begin
        nsamp_s      = {1'b0, count_r} + {{CW{1'b0}}, in_valid[c]};
        pad_s        = BURST_LEN - int'(nsamp_s);
        flush_word_s = shift_next_s;
        for (int k = 0; k < BURST_LEN; k++) begin
          if (k < pad_s) begin
            flush_word_s = flush_word_s >> SAMPLE_W;
          end else begin
            flush_word_s = flush_word_s;
          end
        end
        flush_fire_s = flush[c] && !clear[c] && !word_done_s && (nsamp_s != (CW+1)'(0));
      end
`else
      assign flush_word_s = {WW{1'b0}};
      assign flush_fire_s = 1'b0;
`endif

      assign write_s    = word_done_s || flush_fire_s;
      assign wdata_s    = word_done_s ? shift_next_s : flush_word_s;
      // Until a clear or first write, the pointer has not yet picked up cfg_base.
      assign cur_addr_s = loaded_r ? ptr_r : base_s;
      assign wrap_s     = (cur_addr_s == last_s);
      assign next_ptr_s = wrap_s ? base_s : (cur_addr_s + ADDR_W'(1));

      // Per-channel state and registered BRAM write port.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          count_r   <= {CW{1'b0}};
          shift_r   <= {WW{1'b0}};
          ptr_r     <= {ADDR_W{1'b0}};
          loaded_r  <= 1'b0;
          we_r      <= 1'b0;
          addr_r    <= {ADDR_W{1'b0}};
          data_r    <= {WW{1'b0}};
          cnt_r     <= 16'h0000;
          wrapped_r <= 1'b0;
        end else if (clear[c]) begin
          count_r   <= {CW{1'b0}};
          shift_r   <= {WW{1'b0}};
          ptr_r     <= base_s;
          loaded_r  <= 1'b1;
          we_r      <= 1'b0;
          cnt_r     <= 16'h0000;
          wrapped_r <= 1'b0;
        end else begin
          we_r <= write_s;
          if (flush_fire_s) begin
            count_r <= {CW{1'b0}};
            shift_r <= {WW{1'b0}};
          end else begin
            count_r <= count_next_s;
            shift_r <= shift_next_s;
          end
          if (write_s) begin
            addr_r   <= cur_addr_s;
            data_r   <= wdata_s;
            ptr_r    <= next_ptr_s;
            loaded_r <= 1'b1;
            if (wrap_s) wrapped_r <= 1'b1;
            if (cnt_r != 16'hFFFF) cnt_r <= cnt_r + 16'h0001;
          end
        end
      end

      assign ram_we[c]                  = we_r;
      assign ram_addr[ADDR_W*c +: ADDR_W] = addr_r;
      assign ram_data[WW*c +: WW]        = data_r;
      assign word_cnt[16*c +: 16]        = cnt_r;
      assign wrapped[c]                  = wrapped_r;
    end
  endgenerate
endmodule

// File: tb/tb_burst_packer.sv
// Scoreboard bench for burst_packer: expected BRAM writes are queued per channel and checked as ram_we pulses appear.
module tb_burst_packer;
  localparam int NUM_CH = 2;
  localparam int AW     = 10;
  localparam int WW     = 64;

  logic                 clk;
  logic                 rst_n;
  logic [NUM_CH-1:0]    clear, in_valid, flush;
  logic [32*NUM_CH-1:0] in_data;
  logic [AW*NUM_CH-1:0] cfg_base, cfg_last;
  logic [NUM_CH-1:0]    ram_we;
  logic [AW*NUM_CH-1:0] ram_addr;
  logic [WW*NUM_CH-1:0] ram_data;
  logic [16*NUM_CH-1:0] word_cnt;
  logic [NUM_CH-1:0]    wrapped;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [WW-1:0] data;
  } exp_t;

  exp_t exp_q[NUM_CH][$];
  int   checks = 0;
  int   errors = 0;

  burst_packer #(.NUM_CH(2), .SAMPLE_W(16), .BURST_LEN(4), .ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .flush(flush), .cfg_base(cfg_base), .cfg_last(cfg_last), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_data(ram_data), .word_cnt(word_cnt), .wrapped(wrapped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pop and compare one expected write per observed ram_we pulse.
  always @(negedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (ram_we[c]) begin
        exp_t e;
        checks++;
        if (exp_q[c].size() == 0) begin
          errors++;
          $display("FAIL unexpected_write ch%0d addr=%h data=%h expected no write",
                   c, ram_addr[AW*c +: AW], ram_data[WW*c +: WW]);
        end else begin
          e = exp_q[c].pop_front();
          if (ram_addr[AW*c +: AW] !== e.addr || ram_data[WW*c +: WW] !== e.data) begin
            errors++;
            $display("FAIL write ch%0d addr=%h data=%h expected addr=%h data=%h",
                     c, ram_addr[AW*c +: AW], ram_data[WW*c +: WW], e.addr, e.data);
          end
        end
      end
    end
  end

  function automatic logic [63:0] word4(input logic [15:0] s0, input logic [15:0] s1,
                                        input logic [15:0] s2, input logic [15:0] s3);
    return {s3, s2, s1, s0};
  endfunction

  task automatic push(input int c, input logic [AW-1:0] a, input logic [63:0] d);
    exp_t e;
    e.addr = a;
    e.data = d;
    exp_q[c].push_back(e);
  endtask

  task automatic cycle(input logic [1:0] v, input logic [15:0] d0, input logic [15:0] d1,
                       input logic [1:0] clr, input logic [1:0] fl);
    in_valid = v;
    in_data  = {16'hDEAD, d1, 16'hBEEF, d0};
    clear    = clr;
    flush    = fl;
    @(posedge clk);
    #1;
    in_valid = 2'b00;
    clear    = 2'b00;
    flush    = 2'b00;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(2'b00, 16'h0000, 16'h0000, 2'b00, 2'b00);
  endtask

  task automatic set_cfg(input int c, input logic [AW-1:0] b, input logic [AW-1:0] l);
    cfg_base[AW*c +: AW] = b;
    cfg_last[AW*c +: AW] = l;
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q[0].size() != 0 || exp_q[1].size() != 0) begin
      errors++;
      $display("FAIL %s_pending ch0=%0d ch1=%0d expected 0 0", name, exp_q[0].size(), exp_q[1].size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #12;
    checks++; if (ram_we !== 2'b00) begin errors++; $display("FAIL rst_we %b expected 00", ram_we); end
    checks++; if (ram_addr !== 20'h0) begin errors++; $display("FAIL rst_addr %h expected 0", ram_addr); end
    checks++; if (ram_data !== 128'h0) begin errors++; $display("FAIL rst_data %h expected 0", ram_data); end
    checks++; if (word_cnt !== 32'h0) begin errors++; $display("FAIL rst_word_cnt %h expected 0", word_cnt); end
    checks++; if (wrapped !== 2'b00) begin errors++; $display("FAIL rst_wrapped %b expected 00", wrapped); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    push(0, 10'd0, 64'h0004_0003_0002_0001);
    for (int i = 1; i <= 4; i++) cycle(2'b01, 16'(i), 16'h0000, 2'b00, 2'b00);
    checks++; if (ram_we !== 2'b01) begin errors++; $display("FAIL single_we %b expected 01", ram_we); end
    checks++; if (word_cnt !== 32'h0000_0001) begin errors++; $display("FAIL single_word_cnt %h expected 00000001", word_cnt); end
    idle(2);
    checks++; if (ram_we !== 2'b00) begin errors++; $display("FAIL single_we_idle %b expected 00", ram_we); end
    check_drained("single");
  endtask

  task automatic test_back_to_back();
    cycle(2'b00, 16'h0000, 16'h0000, 2'b11, 2'b00);
    push(0, 10'd0, word4(16'h1000, 16'h1001, 16'h1002, 16'h1003));
    push(0, 10'd1, word4(16'h1004, 16'h1005, 16'h1006, 16'h1007));
    push(1, 10'd0, word4(16'h2000, 16'h2001, 16'h2002, 16'h2003));
    push(1, 10'd1, word4(16'h2004, 16'h2005, 16'h2006, 16'h2007));
    for (int i = 0; i < 8; i++) cycle(2'b11, 16'h1000 + 16'(i), 16'h2000 + 16'(i), 2'b00, 2'b00);
    idle(2);
    checks++; if (word_cnt !== 32'h0002_0002) begin errors++; $display("FAIL b2b_word_cnt %h expected 00020002", word_cnt); end
    checks++; if (wrapped !== 2'b00) begin errors++; $display("FAIL b2b_wrapped %b expected 00", wrapped); end
    check_drained("b2b");
  endtask

  task automatic test_wrap();
    set_cfg(0, 10'd5, 10'd6);
    set_cfg(1, 10'd1023, 10'd0);
    cycle(2'b00, 16'h0000, 16'h0000, 2'b11, 2'b00);
    push(0, 10'd5, word4(16'h3000, 16'h3001, 16'h3002, 16'h3003));
    push(0, 10'd6, word4(16'h3004, 16'h3005, 16'h3006, 16'h3007));
    push(0, 10'd5, word4(16'h3008, 16'h3009, 16'h300A, 16'h300B));
    push(1, 10'd1023, word4(16'h4000, 16'h4001, 16'h4002, 16'h4003));
    push(1, 10'd0,    word4(16'h4004, 16'h4005, 16'h4006, 16'h4007));
    push(1, 10'd1023, word4(16'h4008, 16'h4009, 16'h400A, 16'h400B));
    for (int i = 0; i < 12; i++) begin
      cycle(2'b11, 16'h3000 + 16'(i), 16'h4000 + 16'(i), 2'b00, 2'b00);
      if (i == 3) begin
        checks++; if (wrapped !== 2'b00) begin errors++; $display("FAIL wrap_first %b expected 00", wrapped); end
      end
      if (i == 7) begin
        checks++; if (wrapped !== 2'b11) begin errors++; $display("FAIL wrap_second %b expected 11", wrapped); end
      end
    end
    idle(2);
    checks++; if (word_cnt !== 32'h0003_0003) begin errors++; $display("FAIL wrap_word_cnt %h expected 00030003", word_cnt); end
    check_drained("wrap");
  endtask

  task automatic test_clear_priority();
    set_cfg(0, 10'd0, 10'd1023);
    cycle(2'b00, 16'h0000, 16'h0000, 2'b01, 2'b00);
    for (int i = 1; i <= 3; i++) cycle(2'b01, 16'h5000 + 16'(i), 16'h0000, 2'b00, 2'b00);
    cycle(2'b01, 16'h5004, 16'h0000, 2'b01, 2'b00);
    idle(1);
    checks++; if (word_cnt[15:0] !== 16'h0000) begin errors++; $display("FAIL clr_word_cnt0 %h expected 0000", word_cnt[15:0]); end
    push(0, 10'd0, word4(16'h6001, 16'h6002, 16'h6003, 16'h6004));
    for (int i = 1; i <= 4; i++) cycle(2'b01, 16'h6000 + 16'(i), 16'h0000, 2'b00, 2'b00);
    idle(2);
    checks++; if (word_cnt[15:0] !== 16'h0001) begin errors++; $display("FAIL clr_word_cnt1 %h expected 0001", word_cnt[15:0]); end
    checks++; if (wrapped !== 2'b10) begin errors++; $display("FAIL clr_wrapped %b expected 10", wrapped); end
    check_drained("clear");
  endtask

  task automatic test_flush();
    cycle(2'b00, 16'h0000, 16'h0000, 2'b01, 2'b00);
    cycle(2'b01, 16'hAAAA, 16'h0000, 2'b00, 2'b00);
    cycle(2'b01, 16'hBBBB, 16'h0000, 2'b00, 2'b00);
`ifdef BURST_PACKER_FLUSH_EN
    push(0, 10'd0, 64'h0000_0000_BBBB_AAAA);
    cycle(2'b00, 16'h0000, 16'h0000, 2'b00, 2'b01);
    idle(1);
    cycle(2'b00, 16'h0000, 16'h0000, 2'b00, 2'b01);
    idle(2);
    push(0, 10'd1, word4(16'h0001, 16'h0002, 16'h0003, 16'h0004));
    push(0, 10'd2, word4(16'h0005, 16'h0000, 16'h0000, 16'h0000));
    for (int i = 1; i <= 3; i++) cycle(2'b01, 16'(i), 16'h0000, 2'b00, 2'b00);
    cycle(2'b01, 16'h0004, 16'h0000, 2'b00, 2'b01);
    cycle(2'b01, 16'h0005, 16'h0000, 2'b00, 2'b01);
    idle(2);
    checks++; if (word_cnt[15:0] !== 16'h0003) begin errors++; $display("FAIL flush_word_cnt %h expected 0003", word_cnt[15:0]); end
`else
    cycle(2'b00, 16'h0000, 16'h0000, 2'b00, 2'b01);
    idle(1);
    cycle(2'b00, 16'h0000, 16'h0000, 2'b00, 2'b01);
    idle(2);
    push(0, 10'd0, word4(16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD));
    cycle(2'b01, 16'hCCCC, 16'h0000, 2'b00, 2'b00);
    cycle(2'b01, 16'hDDDD, 16'h0000, 2'b00, 2'b00);
    idle(2);
    checks++; if (word_cnt[15:0] !== 16'h0001) begin errors++; $display("FAIL flush_word_cnt %h expected 0001", word_cnt[15:0]); end
`endif
    check_drained("flush");
  endtask

  task automatic test_reset_mid();
    set_cfg(0, 10'd7, 10'd1023);
    cycle(2'b00, 16'h0000, 16'h0000, 2'b01, 2'b00);
    for (int i = 1; i <= 3; i++) cycle(2'b01, 16'h6F00 + 16'(i), 16'h0000, 2'b00, 2'b00);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ram_data !== 128'h0) begin errors++; $display("FAIL midrst_data %h expected 0", ram_data); end
    checks++; if (ram_addr !== 20'h0) begin errors++; $display("FAIL midrst_addr %h expected 0", ram_addr); end
    checks++; if (word_cnt !== 32'h0) begin errors++; $display("FAIL midrst_word_cnt %h expected 0", word_cnt); end
    checks++; if (wrapped !== 2'b00) begin errors++; $display("FAIL midrst_wrapped %b expected 00", wrapped); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push(0, 10'd7, word4(16'h7001, 16'h7002, 16'h7003, 16'h7004));
    for (int i = 1; i <= 4; i++) cycle(2'b01, 16'h7000 + 16'(i), 16'h0000, 2'b00, 2'b00);
    idle(2);
    checks++; if (word_cnt !== 32'h0000_0001) begin errors++; $display("FAIL midrst_word_cnt_after %h expected 00000001", word_cnt); end
    check_drained("midrst");
  endtask

  initial begin
    clear    = 2'b00;
    in_valid = 2'b00;
    flush    = 2'b00;
    in_data  = 64'h0;
    cfg_base = 20'h0;
    set_cfg(0, 10'd0, 10'd1023);
    set_cfg(1, 10'd0, 10'd1023);
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_clear_priority();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
